// File: rtl/addsub_pkg.sv
// Shared constants for the multi-cycle adder/subtractor: FSM encoding,
// default geometry and the chunk-counter width helper.
package addsub_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_CHUNK_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A one-chunk build still needs a 1-bit counter to stay a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  localparam int unsigned NCHUNK = DEF_WIDTH / DEF_CHUNK_W;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK_W-bit combinational ripple adder; exposes the carry into its MSB so the
// caller can derive signed overflow from the last slice.
module addsub_chunk #(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o,
  output logic               cmsb_o
);

  logic [CHUNK_W:0] c_s;

  // Bit-serial ripple through the slice.
  always_comb begin
    c_s    = '0;
    sum_o  = '0;
    c_s[0] = cin_i;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c_s[CHUNK_W];
  assign cmsb_o = c_s[CHUNK_W-1];

endmodule

// File: rtl/multicycle_addsub32.sv
// Multi-cycle adder/subtractor feeding the SLT stage, one CHUNK_W slice per clock.
// Optional registered zero flag: define ADDSUB_ZERO_FLAG_EN.
module multicycle_addsub32
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CHUNK_W = DEF_CHUNK_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
`ifdef ADDSUB_ZERO_FLAG_EN
  output logic             overflow,
  output logic             zero
`else
  output logic             overflow
`endif
);

  localparam int unsigned N_CH = WIDTH / CHUNK_W;
  localparam int unsigned C_W  = cnt_width(N_CH);
  localparam logic [C_W-1:0] LAST_CNT = C_W'(N_CH - 1);

  if ((WIDTH % CHUNK_W) != 0) begin : g_bad_geometry
    $error("multicycle_addsub32: WIDTH must be a multiple of CHUNK_W");
  end

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic               cmsb_q, cmsb_d;
  logic [C_W-1:0]     cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  logic                     load_s;
  logic [CHUNK_W-1:0]       ch_sum_s;
  logic                     ch_cout_s;
  logic                     ch_cmsb_s;
  logic [WIDTH+CHUNK_W-1:0] part_cat_s;

  addsub_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .a_i    (a_q[CHUNK_W-1:0]),
    .b_i    (b_q[CHUNK_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (ch_sum_s),
    .cout_o (ch_cout_s),
    .cmsb_o (ch_cmsb_s)
  );

  // Operands shift down one slice per cycle; finished slices enter the partial from the top.
  assign part_cat_s = {ch_sum_s, part_q};
  assign load_s     = ready_q & start;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The final slice is registered before publishing, so results load flop-to-flop.
        if (last_q) begin
          state_d = DONE;
          sum_d   = part_q;
          cout_d  = carry_q;
          ovf_d   = carry_q ^ cmsb_q;
`ifdef ADDSUB_ZERO_FLAG_EN
          zero_d  = (part_q == {WIDTH{1'b0}});
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{subtract}};
      carry_d = subtract;
      cmsb_d  = 1'b0;
      cnt_d   = {C_W{1'b0}};
      last_d  = 1'b0;
      part_d  = {WIDTH{1'b0}};
    end else if ((state_q == RUN) && !last_q) begin
      a_d     = a_q >> CHUNK_W;
      b_d     = b_q >> CHUNK_W;
      carry_d = ch_cout_s;
      cmsb_d  = ch_cmsb_s;
      part_d  = part_cat_s[WIDTH+CHUNK_W-1:CHUNK_W];
      if (cnt_q == LAST_CNT) begin
        last_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + C_W'(1);
      end
    end else begin
      last_d  = last_q;
    end

    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= {C_W{1'b0}};
      last_q  <= 1'b0;
      part_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_multicycle_addsub32.sv
// Directed bench for multicycle_addsub32: vector table plus handshake corner sequences.
module tb_multicycle_addsub32;

  localparam int NCH = 4;
  localparam int LAT = NCH + 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic        subtract;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        carryout;
  logic        overflow;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks;
  int errors;

  multicycle_addsub32 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .subtract (subtract),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
`ifdef ADDSUB_ZERO_FLAG_EN
    .overflow (overflow),
    .zero     (zero)
`else
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request from mid-cycle; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    chk("ready_before_accept", {31'd0, ready}, 32'd1);
    a        = av;
    b        = bv;
    subtract = sv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("ready_after_accept", {31'd0, ready}, 32'd0);
  endtask

  // Counts edges until done is seen, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] last_sum;
    logic [31:0] prev;
    bit          seen;

    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    subtract = 1'b0;
    a        = 32'd0;
    b        = 32'd0;

    vecs[0]  = '{32'd5,         32'd3,         1'b0, 32'd8,         1'b0, 1'b0};
    vecs[1]  = '{32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3]  = '{32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         1'b1, 1'b0};
    vecs[5]  = '{32'd7,         32'd7,         1'b1, 32'd0,         1'b1, 1'b0};
    vecs[6]  = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
    vecs[7]  = '{32'd0,         32'd0,         1'b1, 32'd0,         1'b1, 1'b0};
    vecs[8]  = '{32'h0000_00FF, 32'd1,         1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,         1'b1, 1'b1};
    vecs[10] = '{32'h0000_0100, 32'd1,         1'b1, 32'h0000_00FF, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", {31'd0, carryout}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    last_sum = 32'd0;
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      chk("sum_held_during_run", sum, last_sum);
      wait_done(n);
      chk("latency", n, LAT);
      chk("sum", sum, vecs[i].s);
      chk("carryout", {31'd0, carryout}, {31'd0, vecs[i].c});
      chk("overflow", {31'd0, overflow}, {31'd0, vecs[i].v});
      last_sum = vecs[i].s;
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("sum_stable_after_done", sum, last_sum);
    end

    // start during RUN with other operands must be ignored
    start_op(32'd1, 32'd2, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    a        = 32'd100;
    b        = 32'd200;
    subtract = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignores_start", {31'd0, busy}, 32'd1);
    chk("sum_held_ignored_start", sum, last_sum);
    wait_done(n);
    chk("latency_ignored_start", n + 3, LAT);
    chk("sum_original_operands", sum, 32'd3);
    @(posedge clk);
    #1;

    // back-to-back: accept in the DONE cycle
    start_op(32'h0000_1000, 32'h0000_0001, 1'b1);
    wait_done(n);
    chk("b2b_first_latency", n, LAT);
    chk("b2b_first_sum", sum, 32'h0000_0FFF);
    prev = sum;
    start_op(32'h4000_0000, 32'h4000_0000, 1'b0);
    chk("b2b_done_dropped", {31'd0, done}, 32'd0);
    chk("b2b_sum_held", sum, prev);
    wait_done(n);
    chk("b2b_second_latency", n, LAT);
    chk("b2b_second_sum", sum, 32'h8000_0000);
    chk("b2b_second_ovf", {31'd0, overflow}, 32'd1);
    chk("b2b_second_cout", {31'd0, carryout}, 32'd0);
    @(posedge clk);
    #1;

    // reset after two chunks discards the operation
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_cout", {31'd0, carryout}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, seen}, 32'd0);
    chk("sum_zero_after_reset", sum, 32'd0);
    start_op(32'd9, 32'd6, 1'b1);
    wait_done(n);
    chk("recover_latency", n, LAT);
    chk("recover_sum", sum, 32'd3);
    @(posedge clk);
    #1;

`ifdef ADDSUB_ZERO_FLAG_EN
    start_op(32'd7, 32'd7, 1'b1);
    wait_done(n);
    chk("zero_sum", sum, 32'd0);
    chk("zero_flag_set", {31'd0, zero}, 32'd1);
    chk("zero_cout", {31'd0, carryout}, 32'd1);
    @(posedge clk);
    #1;
    start_op(32'd1, 32'd1, 1'b0);
    chk("zero_held_during_run", {31'd0, zero}, 32'd1);
    wait_done(n);
    chk("nonzero_sum", sum, 32'd2);
    chk("zero_flag_clear", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
